// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
package onehot_decoder_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  // Widest select supported by onehot(); callers cast the result down to their own width.
  localparam int ONEHOT_MAX_SEL_W = 8;

  function automatic logic [2**ONEHOT_MAX_SEL_W-1:0] onehot(input logic [ONEHOT_MAX_SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_decoder_tick_div.sv
// Scan-rate divider: tick pulses for one cycle every TICK_DIV running cycles.
// Exists only when ONEHOT_DECODER_SCAN_EN is defined.
`ifdef ONEHOT_DECODER_SCAN_EN
module onehot_decoder_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = run && !clear && (cnt == LAST);

endmodule
`endif

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready load port.
// Auto-scan mode (SCAN state, tick divider, wrap pulse) is built only with ONEHOT_DECODER_SCAN_EN.
module onehot_decoder_seq
  import onehot_decoder_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  en,
  input  logic                  scan_en,
  output logic [(2**SEL_W)-1:0] out_vec,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  out_valid,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic             wrap_nxt;
  logic             load;

  assign load = in_valid && in_ready;

`ifdef ONEHOT_DECODER_SCAN_EN
  logic tick;

  // Counter is held clear outside SCAN, so a fresh scan always waits a full period.
  onehot_decoder_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state != SCAN),
    .run   ((state == SCAN) && scan_en),
    .tick  (tick)
  );

  assign in_ready = (state != SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_nxt;
  end
`else
  logic scan_unused;
  assign scan_unused = scan_en;
  assign in_ready    = 1'b1;
  assign wrap        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = out_idx;
    valid_nxt = out_valid;
    wrap_nxt  = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (load) begin
          idx_nxt   = in_sel;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
`ifdef ONEHOT_DECODER_SCAN_EN
        else if (scan_en) begin
          valid_nxt = 1'b1;
          state_nxt = SCAN;
        end
`endif
      end
`ifdef ONEHOT_DECODER_SCAN_EN
      SCAN: begin
        if (!scan_en) begin
          state_nxt = HOLD;
        end else if (tick) begin
          idx_nxt  = out_idx + 1'b1;
          wrap_nxt = &out_idx;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_idx   <= idx_nxt;
      out_valid <= valid_nxt;
    end
  end

  // en gates only the decode, never the registered index.
  assign out_vec = (out_valid && en) ? OUT_W'(onehot(ONEHOT_MAX_SEL_W'(out_idx))) : '0;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq: per-cycle model compare plus directed literal checks.
module tb_onehot_decoder_seq;

  localparam int SEL_W = 3;
  localparam int TD    = 2;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             en;
  logic             scan_en;
  logic [OUT_W-1:0] out_vec;
  logic [SEL_W-1:0] out_idx;
  logic             out_valid;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  onehot_decoder_seq #(.SEL_W(SEL_W), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .en        (en),
    .scan_en   (scan_en),
    .out_vec   (out_vec),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

`ifdef ONEHOT_DECODER_SCAN_EN
  localparam bit HAS_SCAN = 1'b1;
`else
  localparam bit HAS_SCAN = 1'b0;
`endif

  // Behavioural model: scanning flag, index, how many cycles spent at the current scan position.
  bit m_scan  = 1'b0;
  int m_idx   = 0;
  int m_phase = 0;
  bit m_valid = 1'b0;
  bit m_wrap  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan <= 1'b0; m_idx <= 0; m_phase <= 0; m_valid <= 1'b0; m_wrap <= 1'b0;
    end else begin
      m_wrap <= 1'b0;
      if (!m_scan) begin
        if (in_valid) begin
          m_idx <= in_sel; m_valid <= 1'b1;
        end else if (HAS_SCAN && scan_en) begin
          m_scan <= 1'b1; m_valid <= 1'b1; m_phase <= 0;
        end
      end else if (!scan_en) begin
        m_scan <= 1'b0;
      end else if (m_phase + 1 == TD) begin
        m_phase <= 0;
        m_idx   <= (m_idx + 1) % OUT_W;
        m_wrap  <= (m_idx == OUT_W - 1);
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_vec",   32'(out_vec),   (m_valid && en) ? (32'd1 << m_idx) : 32'd0);
    chk("model_idx",   32'(out_idx),   32'(m_idx));
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_ready", 32'(in_ready),  32'(!m_scan));
    chk("model_wrap",  32'(wrap),      32'(m_wrap));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [2:0] scan_idx  [6] = '{3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
  logic       scan_wrap [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; en = 1'b1; scan_en = 1'b0;
    #1;
    chk("rst_vec", 32'(out_vec), 32'h0);
    chk("rst_idx", 32'(out_idx), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_wrap", 32'(wrap), 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // load sweep
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'(i);
      cyc();
      chk("sweep_vec", 32'(out_vec), 32'(sweep_tbl[i]));
      chk("sweep_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;

    // enable gating
    in_valid = 1'b1; in_sel = 3'd3;
    cyc();
    in_valid = 1'b0; en = 1'b0;
    #1;
    chk("gate_off_vec", 32'(out_vec), 32'h0);
    chk("gate_off_idx", 32'(out_idx), 32'h3);
    cyc();
    chk("gate_hold_idx", 32'(out_idx), 32'h3);
    en = 1'b1;
    #1;
    chk("gate_on_vec", 32'(out_vec), 32'h08);

`ifdef ONEHOT_DECODER_SCAN_EN
    // scan with wrap: load 6 with scan_en, scan entered one cycle later
    in_valid = 1'b1; in_sel = 3'd6; scan_en = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("scan_load_idx", 32'(out_idx), 32'h6);
    chk("scan_load_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("scan_entry_ready", 32'(in_ready), 32'h0);
    chk("scan_entry_idx", 32'(out_idx), 32'h6);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("scan_seq_idx", 32'(out_idx), 32'(scan_idx[k]));
      chk("scan_seq_wrap", 32'(wrap), 32'(scan_wrap[k]));
    end
    scan_en = 1'b0;
    cyc();
    chk("scan_exit_ready", 32'(in_ready), 32'h1);
    chk("scan_exit_idx", 32'(out_idx), 32'h1);
    chk("scan_exit_wrap", 32'(wrap), 32'h0);

    // simultaneous load + scan_en from HOLD at 2
    in_valid = 1'b1; in_sel = 3'd2;
    cyc();
    in_sel = 3'd5; scan_en = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("simul_idx", 32'(out_idx), 32'h5);
    chk("simul_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("simul_ready_low", 32'(in_ready), 32'h0);
    cyc();
    chk("simul_wait_idx", 32'(out_idx), 32'h5);
    cyc();
    chk("simul_step_idx", 32'(out_idx), 32'h6);

    // park at 4 and scan, then reset mid-scan
    scan_en = 1'b0;
    cyc();
    in_valid = 1'b1; in_sel = 3'd4;
    cyc();
    in_valid = 1'b0; scan_en = 1'b1;
    cyc();
    cyc();
    chk("pre_rst_idx", 32'(out_idx), 32'h4);
    chk("pre_rst_ready", 32'(in_ready), 32'h0);
`else
    // scan_en is ignored: the index holds and in_ready stays high
    scan_en = 1'b1; in_valid = 1'b1; in_sel = 3'd7;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("noscan_idx", 32'(out_idx), 32'h7);
      chk("noscan_wrap", 32'(wrap), 32'h0);
      chk("noscan_ready", 32'(in_ready), 32'h1);
    end
    in_valid = 1'b1; in_sel = 3'd4;
    cyc();
    in_valid = 1'b0;
`endif

    // asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vec", 32'(out_vec), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_wrap", 32'(wrap), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h1);
    scan_en = 1'b0;
    cyc();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 3'd1;
    cyc();
    in_valid = 1'b0;
    chk("post_rst_vec", 32'(out_vec), 32'h02);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
